// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM states and byte-lane helpers for the memory access stage
`timescale 1ns/1ps
package mem_pkg;
    localparam logic [1:0] WR_LOAD  = 2'b01;
    localparam logic [1:0] WR_STORE = 2'b10;
    localparam logic [1:0] SZ_B     = 2'b00;
    localparam logic [1:0] SZ_H     = 2'b01;
    localparam logic [1:0] SZ_W     = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        return sz == SZ_B ? 4'b0001 << a : sz == SZ_H ? 4'b0011 << {a[1], 1'b0} : sz == SZ_W ? 4'b1111 : 4'b0000;
    endfunction
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        return sz == SZ_B || (sz == SZ_H && !a[0]) || (sz == SZ_W && a == 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-enable/data steering and load lane extraction with sign/zero extension
`timescale 1ns/1ps
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);
    logic [31:0] lane;
    always_comb begin
        be = lane_mask(size, a);
        wdata_lane = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
        lane = rdata_raw >> {a, 3'b000};
        load_data = size == SZ_B ? {{24{sign & lane[7]}}, lane[7:0]}
                  : size == SZ_H ? {{16{sign & lane[15]}}, lane[15:0]} : lane;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine on a req/ack word bus with timeout
`timescale 1ns/1ps
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_mem,
    input  logic [1:0]        W_R_mem,
    input  logic [1:0]        wordsize_mem,
    input  logic              sign_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy_mem,
    output logic              done_mem,
    output logic              aligned_mem,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e state, state_nx;
    logic armed, accept, timeout, err, a_we, a_sign;
    logic [1:0] a_size;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, wd_lane, load_data;
    logic [3:0] be;
    logic [CW-1:0] cnt;

    mem_lane_align u_align (
        .size      (a_size),
        .a         (a_addr[1:0]),
        .sign      (a_sign),
        .wdata     (a_wdata),
        .rdata_raw (bus_rdata),
        .be        (be),
        .wdata_lane(wd_lane),
        .load_data (load_data)
    );

    assign aligned_mem = is_aligned(wordsize_mem, addr[1:0]);
    assign bus_req     = state == REQ || state == WAIT;
    assign busy_mem    = bus_req;
    assign done_mem    = state == DONE;
    assign bus_err     = done_mem & err;
    assign bus_we      = bus_req & a_we;
    assign bus_addr    = bus_req ? {a_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be      = bus_req ? be : 4'b0000;
    assign bus_wdata   = bus_req ? wd_lane : '0;

    always_comb begin
        state_nx = state;
        accept = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                accept = en_mem && armed && aligned_mem && (W_R_mem == WR_LOAD || W_R_mem == WR_STORE);
                state_nx = accept ? REQ : IDLE;
            end
            REQ: state_nx = bus_ack ? DONE : WAIT;
            WAIT: begin
                timeout = !bus_ack && (cnt + CW'(1) == CW'(TIMEOUT));
                state_nx = (bus_ack || timeout) ? DONE : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            armed   <= 1'b1;
            cnt     <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            a_addr  <= '0;
            a_wdata <= '0;
            a_size  <= SZ_B;
            a_sign  <= 1'b0;
            a_we    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == WAIT ? cnt + CW'(1) : '0;
            err   <= timeout;
            // re-arm only once the request level has been seen low while idle
            if (state == IDLE && !en_mem)
                armed <= 1'b1;
            if (accept) begin
                armed   <= 1'b0;
                a_addr  <= addr;
                a_wdata <= wdata;
                a_size  <= wordsize_mem;
                a_sign  <= sign_mem;
                a_we    <= W_R_mem == WR_STORE;
            end
            if (bus_req && bus_ack && !a_we)
                rdata <= load_data;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for mem_access_unit
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int TO = 4;
    logic clk = 1'b0, reset = 1'b0;
    logic en_mem = 1'b0, sign_mem = 1'b0, bus_ack = 1'b0;
    logic [1:0] W_R_mem = 2'b00, wordsize_mem = 2'b00;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic busy_mem, done_mem, aligned_mem, bus_err, bus_req, bus_we;
    logic [3:0] bus_be;
    int n_cmp = 0, n_fail = 0;
    logic [31:0] exp_rdata = '0;
    logic [3:0] o_be;
    logic [31:0] o_wd, o_addr, o_rdata;
    logic o_we, o_err, o_stable;
    int o_req, o_done, o_lat, o_busy_bad;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .en_mem(en_mem), .W_R_mem(W_R_mem),
        .wordsize_mem(wordsize_mem), .sign_mem(sign_mem), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy_mem(busy_mem), .done_mem(done_mem), .aligned_mem(aligned_mem),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] rd);
        longint sh, mask, v;
        int bits;
        bits = 8 * nbytes(sz);
        sh = longint'(rd) >> (8 * (a % 4));
        mask = (longint'(1) << bits) - 1;
        v = sh & mask;
        if (sg && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
        return 32'(v);
    endfunction

    function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 ? 1'b0 : (a % nbytes(sz)) == 0;
    endfunction

    // Drives one access and records what the bus and handshake outputs did; never compares.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        en_mem = 1'b1; W_R_mem = we ? 2'b10 : 2'b01; wordsize_mem = sz; sign_mem = sg;
        addr = a; wdata = wd; bus_rdata = rd; bus_ack = 1'b0;
        @(posedge clk); #1;
        en_mem = 1'b0; addr = $urandom; wdata = $urandom; wordsize_mem = 2'($urandom);
        sign_mem = 1'($urandom); W_R_mem = 2'($urandom);
        o_be = bus_be; o_wd = bus_wdata; o_addr = bus_addr; o_we = bus_we; o_stable = 1'b1;
        o_req = 0; o_done = 0; o_lat = 0; o_busy_bad = 0; o_err = 1'b0; o_rdata = rdata;
        for (int c = 0; c < TO + 4; c++) begin
            if (bus_req) begin
                o_req++;
                if (bus_be !== o_be || bus_wdata !== o_wd || bus_addr !== o_addr || bus_we !== o_we) o_stable = 1'b0;
            end
            if (busy_mem !== bus_req) o_busy_bad++;
            if (done_mem) begin o_done++; o_err = bus_err; o_lat = c + 1; o_rdata = rdata; end
            bus_ack = (c == ack_at);
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_req, busy_mem, done_mem, bus_err, bus_we, bus_be, bus_addr, bus_wdata, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b busy=%b done=%b err=%b we=%b be=%h addr=%h wd=%h rdata=%h want all zero",
                     bus_req, busy_mem, done_mem, bus_err, bus_we, bus_be, bus_addr, bus_wdata, rdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word;
        run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        n_cmp++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL sw_be got %h want f", o_be); end
        n_cmp++; if (o_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", o_wd); end
        n_cmp++; if (o_addr !== 32'h100 || o_we !== 1'b1) begin n_fail++; $display("FAIL sw_addr_we got %h/%b want 100/1", o_addr, o_we); end
        n_cmp++; if (o_req !== 1) begin n_fail++; $display("FAIL sw_busy_cycles got %0d want 1", o_req); end
        n_cmp++; if (o_lat !== 2 || o_done !== 1) begin n_fail++; $display("FAIL sw_done got lat=%0d n=%0d want lat=2 n=1", o_lat, o_done); end
        n_cmp++; if (o_err !== 1'b0 || o_busy_bad !== 0) begin n_fail++; $display("FAIL sw_err_busy got err=%b busybad=%0d want 0/0", o_err, o_busy_bad); end
    endtask

    task automatic test_load_extend;
        run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0011, 3);
        exp_rdata = 32'hFFFFFF80;
        n_cmp++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL lb_signed got %h want %h", o_rdata, exp_rdata); end
        n_cmp++; if (o_req !== 4 || o_err !== 1'b0 || o_done !== 1) begin n_fail++; $display("FAIL lb_handshake got req=%0d err=%b done=%0d want 4/0/1", o_req, o_err, o_done); end
        run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF0011, 3);
        exp_rdata = 32'h00000080;
        n_cmp++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL lb_unsigned got %h want %h", o_rdata, exp_rdata); end
        run_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80FF0011, 3);
        exp_rdata = 32'hFFFF80FF;
        n_cmp++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL lh_signed got %h want %h", o_rdata, exp_rdata); end
        n_cmp++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got %b want 1100", o_be); end
    endtask

    task automatic test_misaligned;
        int rq, dn;
        logic [1:0] sz;
        logic [31:0] a;
        W_R_mem = 2'b10; wdata = 32'h1234; en_mem = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wordsize_mem = k == 0 ? 2'b01 : 2'b11;
            addr = k == 0 ? 32'h101 : 32'h100;
            #1;
            n_cmp++; if (aligned_mem !== 1'b0) begin n_fail++; $display("FAIL mis_aligned%0d got %b want 0", k, aligned_mem); end
            rq = 0; dn = 0;
            repeat (4) begin @(posedge clk); #1; rq += int'(bus_req | busy_mem); dn += int'(done_mem); end
            n_cmp++; if (rq !== 0 || dn !== 0) begin n_fail++; $display("FAIL mis_activity%0d got req=%0d done=%0d want 0/0", k, rq, dn); end
        end
        en_mem = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom); a = $urandom;
            wordsize_mem = sz; addr = a;
            #1;
            n_cmp++; if (aligned_mem !== m_aligned(sz, a)) begin n_fail++; $display("FAIL align_table sz=%0d a=%h got %b want %b", sz, a, aligned_mem, m_aligned(sz, a)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, -1);
        n_cmp++; if (o_req !== TO + 1) begin n_fail++; $display("FAIL to_req_cycles got %0d want %0d", o_req, TO + 1); end
        n_cmp++; if (o_done !== 1 || o_err !== 1'b1 || o_lat !== TO + 2) begin n_fail++; $display("FAIL to_done got n=%0d err=%b lat=%0d want 1/1/%0d", o_done, o_err, o_lat, TO + 2); end
        n_cmp++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL to_rdata_held got %h want %h", o_rdata, exp_rdata); end
    endtask

    task automatic test_back_to_back;
        int dn, rq;
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; sign_mem = 1'b0;
        addr = 32'h200; bus_rdata = 32'h12345678; bus_ack = 1'b1; dn = 0; rq = 0;
        repeat (10) begin @(posedge clk); #1; dn += int'(done_mem); rq += int'(bus_req); end
        exp_rdata = 32'h12345678;
        n_cmp++; if (dn !== 1 || rq !== 1) begin n_fail++; $display("FAIL held_en_one_txn got done=%0d req=%0d want 1/1", dn, rq); end
        n_cmp++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL held_en_rdata got %h want %h", rdata, exp_rdata); end
        en_mem = 1'b0;
        @(posedge clk); #1;
        en_mem = 1'b1; bus_rdata = 32'h9ABCDEF0; dn = 0;
        repeat (5) begin @(posedge clk); #1; dn += int'(done_mem); end
        exp_rdata = 32'h9ABCDEF0;
        n_cmp++; if (dn !== 1 || rdata !== exp_rdata) begin n_fail++; $display("FAIL rearm_second_txn got done=%0d rdata=%h want 1/%h", dn, rdata, exp_rdata); end
        en_mem = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait;
        int dn;
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h300; bus_ack = 1'b0;
        @(posedge clk); #1;
        en_mem = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait got req=%b want 1", bus_req); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || busy_mem !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL rst_immediate got req=%b busy=%b rdata=%h want 0/0/0", bus_req, busy_mem, rdata); end
        dn = 0;
        repeat (3) begin @(posedge clk); #1; dn += int'(done_mem); end
        n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL rst_no_done got %0d want 0", dn); end
        reset = 1'b1; exp_rdata = '0;
        @(posedge clk); #1;
        run_access(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 32'h00008000, 1);
        exp_rdata = 32'hFFFFFF80;
        n_cmp++; if (o_rdata !== exp_rdata || o_done !== 1 || o_err !== 1'b0) begin n_fail++; $display("FAIL rst_next_access got rdata=%h done=%0d err=%b want %h/1/0", o_rdata, o_done, o_err, exp_rdata); end
    endtask

    task automatic test_random;
        logic we, sg, acked;
        logic [1:0] sz;
        logic [31:0] a, wd, rd;
        int k;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 2));
            a = $urandom & ~(32'(nbytes(sz)) - 32'd1); wd = $urandom; rd = $urandom;
            k = $urandom_range(0, TO + 1);
            acked = k <= TO;
            run_access(we, sz, sg, a, wd, rd, acked ? k : -1);
            if (!we && acked) exp_rdata = m_ld(sz, sg, a, rd);
            n_cmp++; if (o_be !== m_be(sz, a) || o_wd !== m_wd(sz, wd)) begin n_fail++; $display("FAIL rnd%0d_lanes got be=%h wd=%h want be=%h wd=%h", i, o_be, o_wd, m_be(sz, a), m_wd(sz, wd)); end
            n_cmp++; if (o_addr !== {a[31:2], 2'b00} || o_we !== we || !o_stable) begin n_fail++; $display("FAIL rnd%0d_bus got addr=%h we=%b stable=%b want %h/%b/1", i, o_addr, o_we, o_stable, {a[31:2], 2'b00}, we); end
            n_cmp++; if (o_req !== (acked ? k + 1 : TO + 1) || o_busy_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_req got %0d busybad=%0d want %0d", i, o_req, o_busy_bad, acked ? k + 1 : TO + 1); end
            n_cmp++; if (o_done !== 1 || o_err !== !acked || o_lat !== (acked ? k + 2 : TO + 2)) begin n_fail++; $display("FAIL rnd%0d_done got n=%0d err=%b lat=%0d want 1/%b/%0d", i, o_done, o_err, o_lat, !acked, acked ? k + 2 : TO + 2); end
            n_cmp++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, o_rdata, exp_rdata); end
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_load_extend;
        test_misaligned;
        test_timeout;
        test_back_to_back;
        test_reset_mid_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
